div_sign_ctrl: RTL and testbench

//  Front-end controller for the 16-bit unsigned non-restoring divider core in the ALU.

---
 rtl/div_sign_ctrl_pkg.sv | 26 ++
 rtl/div_sign_ctrl_if.sv | 52 +++++
 rtl/div_sign_ctrl_twos_neg.sv | 22 ++
 rtl/div_sign_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_div_sign_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_sign_ctrl_pkg.sv
// Shared definitions for the divider sign-control front end: default width,
// timeout budget, FSM state encoding and the two special result constants.
package div_sign_ctrl_pkg;

  // Operand/result width of the unsigned divider core in the ALU.
  localparam int DIV_W = 16;

  // Cycles the controller waits for the core before giving up.
  localparam int DIV_TIMEOUT = 40;

  // Quotient reported for a divide by zero (all ones).
  localparam logic [DIV_W-1:0] DZ_QUOT = {DIV_W{1'b1}};

  // Most negative two's-complement value; its magnitude is itself.
  localparam logic [DIV_W-1:0] SMIN = {1'b1, {(DIV_W-1){1'b0}}};

  // Controller states, binary encoded.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FIX   = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/div_sign_ctrl_if.sv
// Bundle of the three channels around the sign controller: request from the
// command decoder, result to the UART formatter, and the divider core link.
// "slave" is the controller's view; "master" is the surrounding ALU's view.
interface div_sign_ctrl_if
  import div_sign_ctrl_pkg::*;
#(
  parameter int W = DIV_W
) ();

  // Request channel
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_signed;

  // Result channel
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quot;
  logic [W-1:0] out_rem;
  logic         out_dz;
  logic         out_ovf;
  logic         out_err;

  // Divider core link
  logic         div_start;
  logic [W-1:0] div_Q;
  logic [W-1:0] div_M;
  logic [W-1:0] div_quotient;
  logic [W-1:0] div_remain;
  logic         div_done;

  modport slave (
    input  in_valid, in_a, in_b, in_signed,
    output in_ready,
    output out_valid, out_quot, out_rem, out_dz, out_ovf, out_err,
    input  out_ready,
    output div_start, div_Q, div_M,
    input  div_quotient, div_remain, div_done
  );

  modport master (
    output in_valid, in_a, in_b, in_signed,
    input  in_ready,
    input  out_valid, out_quot, out_rem, out_dz, out_ovf, out_err,
    output out_ready,
    input  div_start, div_Q, div_M,
    output div_quotient, div_remain, div_done
  );

endinterface

// File: rtl/div_sign_ctrl_twos_neg.sv
// Conditional two's-complement negate: y = en ? -x : x (mod 2^W).
// Used for operand magnitudes and for restoring the sign of the results.
module twos_neg #(
  parameter int W = 16
) (
  input  logic         en,
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  // Negate when enabled, otherwise pass the value through unchanged.
  always_comb begin
    if (en) begin
      y = ~x + ONE;
    end else begin
      y = x;
    end
  end

endmodule

// File: rtl/div_sign_ctrl.sv
// Sign-handling front end for the unsigned divider core. Takes a signed or
// unsigned request, feeds magnitudes to the core, restores signs on the way
// back (truncation toward zero), and short-circuits divide-by-zero and the
// MIN/-1 overflow without starting the core. Results are held until taken.
module div_sign_ctrl
  import div_sign_ctrl_pkg::*;
#(
  parameter int W       = DIV_W,
  parameter int TIMEOUT = DIV_TIMEOUT
) (
  input  logic            clk,
  input  logic            n_rst,
  div_sign_ctrl_if.slave  bus
);

  localparam int            CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0]  ZERO     = {W{1'b0}};
  localparam logic [W-1:0]  MIN_VAL  = {1'b1, {(W-1){1'b0}}};

  // FSM and datapath registers
  state_t         state_r;
  logic           in_ready_r;
  logic           sa_r;
  logic           sb_r;
  logic [CW-1:0]  cnt_r;
  logic [W-1:0]   q_r;
  logic [W-1:0]   r_r;
  logic [W-1:0]   div_q_r;
  logic [W-1:0]   div_m_r;
  logic           div_start_r;
  logic           out_valid_r;
  logic [W-1:0]   out_quot_r;
  logic [W-1:0]   out_rem_r;
  logic           out_dz_r;
  logic           out_ovf_r;
  logic           out_err_r;

  // Combinational helpers
  logic           sa_s;
  logic           sb_s;
  logic [W-1:0]   mag_a_s;
  logic [W-1:0]   mag_b_s;
  logic [W-1:0]   fix_q_s;
  logic [W-1:0]   fix_r_s;
  logic           accept_s;
  logic           b_zero_s;
  logic           ovf_case_s;

  assign sa_s       = bus.in_signed & bus.in_a[W-1];
  assign sb_s       = bus.in_signed & bus.in_b[W-1];
  assign accept_s   = bus.in_valid & in_ready_r;
  assign b_zero_s   = (bus.in_b == ZERO);
  assign ovf_case_s = bus.in_signed & (bus.in_a == MIN_VAL) & (bus.in_b == ALL_ONES);

  // Operand magnitudes; MIN maps to itself and the core reads it unsigned.
  twos_neg #(.W(W)) u_neg_a (.en(sa_s), .x(bus.in_a), .y(mag_a_s));
  twos_neg #(.W(W)) u_neg_b (.en(sb_s), .x(bus.in_b), .y(mag_b_s));

  // Quotient negative when operand signs differ; remainder follows the dividend.
  twos_neg #(.W(W)) u_neg_q (.en(sa_r ^ sb_r), .x(q_r), .y(fix_q_s));
  twos_neg #(.W(W)) u_neg_r (.en(sa_r),        .x(r_r), .y(fix_r_s));

  // Request/issue/wait/fix/hold sequencing with all outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      sa_r        <= 1'b0;
      sb_r        <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      q_r         <= ZERO;
      r_r         <= ZERO;
      div_q_r     <= ZERO;
      div_m_r     <= ZERO;
      div_start_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_quot_r  <= ZERO;
      out_rem_r   <= ZERO;
      out_dz_r    <= 1'b0;
      out_ovf_r   <= 1'b0;
      out_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            sa_r       <= sa_s;
            sb_r       <= sb_s;
            div_q_r    <= mag_a_s;
            div_m_r    <= mag_b_s;
            in_ready_r <= 1'b0;
            out_dz_r   <= 1'b0;
            out_ovf_r  <= 1'b0;
            out_err_r  <= 1'b0;
            if (b_zero_s) begin
              // Divide by zero never reaches the core.
              out_quot_r  <= ALL_ONES;
              out_rem_r   <= bus.in_a;
              out_dz_r    <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
            end else if (ovf_case_s) begin
              // MIN / -1 does not fit; report the wrapped quotient.
              out_quot_r  <= MIN_VAL;
              out_rem_r   <= ZERO;
              out_ovf_r   <= 1'b1;
              out_valid_r <= 1'b1;
              state_r     <= ST_HOLD;
            end else begin
              div_start_r <= 1'b1;
              state_r     <= ST_ISSUE;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          // Start is high for exactly this one cycle.
          div_start_r <= 1'b0;
          cnt_r       <= {CW{1'b0}};
          state_r     <= ST_WAIT;
        end

        ST_WAIT: begin
          if (bus.div_done) begin
            // Done wins over a coincident timeout.
            q_r     <= bus.div_quotient;
            r_r     <= bus.div_remain;
            state_r <= ST_FIX;
          end else if (cnt_r == CNT_LAST) begin
            out_quot_r  <= ZERO;
            out_rem_r   <= ZERO;
            out_err_r   <= 1'b1;
            out_valid_r <= 1'b1;
            state_r     <= ST_HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        ST_FIX: begin
          out_quot_r  <= fix_q_s;
          out_rem_r   <= fix_r_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_HOLD;
        end

        ST_HOLD: begin
          // Results and flags stay put until the consumer takes them.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_HOLD;
          end
        end

        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          div_start_r <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.div_start = div_start_r;
  assign bus.div_Q     = div_q_r;
  assign bus.div_M     = div_m_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_quot  = out_quot_r;
  assign bus.out_rem   = out_rem_r;
  assign bus.out_dz    = out_dz_r;
  assign bus.out_ovf   = out_ovf_r;
  assign bus.out_err   = out_err_r;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// Scoreboard bench for div_sign_ctrl with a behavioural divider core.
// Expected results come from integer arithmetic on the operands.
module tb_div_sign_ctrl;
  import div_sign_ctrl_pkg::*;

  localparam int TW   = 16;
  localparam int TOUT = 40;

  typedef struct {
    logic [15:0] quot;
    logic [15:0] rem;
    logic [15:0] mag_a;
    logic [15:0] mag_b;
    logic        dz;
    logic        ovf;
    logic        err;
    int          starts;
    int          lat;
    int          start_base;
    int          acc_cyc;
  } exp_t;

  logic clk;
  logic n_rst;
  div_sign_ctrl_if #(.W(TW)) bus ();

  div_sign_ctrl #(.W(TW), .TIMEOUT(TOUT)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_total = 0;
  int   last_hs_cyc = -10;
  int   core_lat = 1;
  bit   core_dead = 1'b0;
  bit   rand_mode = 1'b0;
  int   bp_hold = 0;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: plain integer division, C-style truncation toward zero.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sgn, input int lat, input bit dead);
    exp_t e;
    int ia, ib, iq, ir;
    e = '{default: 0};
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    e.mag_a = 16'((ia < 0) ? -ia : ia);
    e.mag_b = 16'((ib < 0) ? -ib : ib);
    if (ib == 0) begin
      e.quot = 16'hFFFF; e.rem = a; e.dz = 1'b1; e.starts = 0; e.lat = 1;
    end else if (sgn && ia == -32768 && ib == -1) begin
      e.quot = 16'h8000; e.rem = 16'h0000; e.ovf = 1'b1; e.starts = 0; e.lat = 1;
    end else if (dead) begin
      e.quot = 16'h0000; e.rem = 16'h0000; e.err = 1'b1; e.starts = 1; e.lat = TOUT + 2;
    end else begin
      iq = ia / ib;
      ir = ia % ib;
      e.quot = 16'(iq); e.rem = 16'(ir); e.starts = 1; e.lat = lat + 3;
    end
    return e;
  endfunction

  // Behavioural divider core: done is high lat cycles after the start cycle.
  logic [15:0] core_q, core_r;
  logic        core_done;
  int          core_cnt;
  bit          core_dead_r;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      core_q <= 16'h0; core_r <= 16'h0; core_done <= 1'b0;
      core_cnt <= 0; core_dead_r <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (bus.div_start) begin
        core_q      <= (bus.div_M != 16'h0) ? bus.div_Q / bus.div_M : 16'hFFFF;
        core_r      <= (bus.div_M != 16'h0) ? bus.div_Q % bus.div_M : bus.div_Q;
        core_dead_r <= core_dead;
        core_cnt    <= core_lat - 1;
        core_done   <= (!core_dead && core_lat == 1);
      end else if (core_dead_r) begin
        core_done <= 1'b0;
      end else if (core_cnt != 0) begin
        core_cnt  <= core_cnt - 1;
        core_done <= (core_cnt == 1);
      end else begin
        core_done <= ($urandom_range(0, 7) == 0);
      end
    end
  end
  assign bus.div_quotient = core_q;
  assign bus.div_remain   = core_r;
  assign bus.div_done     = core_done;

  // Consumer: drives out_ready just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (bus.out_valid && bp_hold > 0) begin
        bus.out_ready = 1'b0;
        bp_hold--;
      end else if (rand_mode) begin
        bus.out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake.
  initial begin
    exp_t e;
    bit prev_valid, prev_stall, prev_hs;
    logic [15:0] s_q, s_r;
    logic [2:0]  s_f;
    int first_cyc;
    prev_valid = 0; prev_stall = 0; prev_hs = 0; first_cyc = 0;
    s_q = 16'h0; s_r = 16'h0; s_f = 3'b000;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        prev_valid = 0; prev_stall = 0; prev_hs = 0;
      end else begin
        if (bus.div_start) begin
          start_total++;
          if (exp_q.size() > 0) begin
            check("div_Q", bus.div_Q, exp_q[0].mag_a);
            check("div_M", bus.div_M, exp_q[0].mag_b);
          end
        end
        if (prev_hs) check("valid_drop", bus.out_valid, 1'b0);
        prev_hs = 0;
        if (bus.out_valid) begin
          if (!prev_valid) first_cyc = cyc;
          check("in_ready_in_hold", bus.in_ready, 1'b0);
          if (prev_stall) begin
            check("stall_quot", bus.out_quot, s_q);
            check("stall_rem", bus.out_rem, s_r);
            check("stall_flags", {bus.out_dz, bus.out_ovf, bus.out_err}, s_f);
          end
          if (bus.out_ready) begin
            if (exp_q.size() == 0) begin
              check("unexpected_result", 1'b1, 1'b0);
            end else begin
              e = exp_q.pop_front();
              check("quot", bus.out_quot, e.quot);
              check("rem", bus.out_rem, e.rem);
              check("dz", bus.out_dz, e.dz);
              check("ovf", bus.out_ovf, e.ovf);
              check("err", bus.out_err, e.err);
              check("latency", first_cyc - e.acc_cyc, e.lat);
              check("start_pulses", start_total - e.start_base, e.starts);
            end
            last_hs_cyc = cyc;
            prev_hs = 1;
          end
          prev_stall = !bus.out_ready;
          s_q = bus.out_quot; s_r = bus.out_rem;
          s_f = {bus.out_dz, bus.out_ovf, bus.out_err};
        end else begin
          prev_stall = 0;
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  // Issue one request; called and returns just after a falling edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                      input int lat, input bit dead, input bit btb);
    exp_t e;
    bit got;
    e = model(a, b, sgn, lat, dead);
    bus.in_a = a; bus.in_b = b; bus.in_signed = sgn; bus.in_valid = 1'b1;
    got = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus.in_ready) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    if (got) begin
      core_lat = lat; core_dead = dead;
      e.acc_cyc = cyc; e.start_base = start_total;
      if (btb) check("back_to_back_accept", cyc, last_hs_cyc + 1);
      exp_q.push_back(e);
    end else begin
      check("accept_timeout", bus.in_ready, 1'b1);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 500; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_quot"}, bus.out_quot, 16'h0);
    check({tag, "_rem"}, bus.out_rem, 16'h0);
    check({tag, "_flags"}, {bus.out_dz, bus.out_ovf, bus.out_err}, 3'b000);
    check({tag, "_div_start"}, bus.div_start, 1'b0);
    check({tag, "_div_QM"}, {bus.div_Q, bus.div_M}, 32'h0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    logic [15:0] a, b;
    logic        sgn;
    logic [15:0] corners [0:5];
    corners[0] = 16'h8000; corners[1] = 16'h7FFF; corners[2] = 16'h0000;
    corners[3] = 16'hFFFF; corners[4] = 16'h0001; corners[5] = 16'hFFFE;
    n_rst = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = 16'h0; bus.in_b = 16'h0; bus.in_signed = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    send(16'd100,  16'd7,   1'b0, 4, 0, 0); drain();
    send(16'hFF9C, 16'd7,   1'b1, 2, 0, 0); drain();
    send(16'd100,  16'hFFF9, 1'b1, 1, 0, 0); drain();
    send(16'h1234, 16'h0,   1'b0, 3, 0, 0); drain();
    send(16'h1234, 16'h0,   1'b1, 3, 0, 0); drain();
    send(16'h8000, 16'hFFFF, 1'b1, 3, 0, 0); drain();
    send(16'h8000, 16'hFFFF, 1'b0, 3, 0, 0); drain();
    send(16'h8000, 16'h0003, 1'b1, 5, 0, 0); drain();

    // Backpressure: consumer refuses the result for five cycles.
    bp_hold = 5;
    send(16'hFFF9, 16'd2, 1'b1, 3, 0, 0); drain();
    bp_hold = 0;

    // Core never answers: timeout error.
    send(16'h0010, 16'd3, 1'b0, 1, 1, 0); drain();

    // Back-to-back requests accepted the cycle after each handshake.
    send(16'h0042, 16'h0000, 1'b0, 2, 0, 0);
    send(16'h0042, 16'h0005, 1'b0, 2, 0, 1);
    send(16'hFF00, 16'h0010, 1'b1, 1, 0, 1); drain();

    // Reset while waiting on the core aborts the request silently.
    send(16'h0100, 16'h0003, 1'b0, 1, 1, 0);
    repeat (5) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check_idle_outputs("mid_wait_reset");
    exp_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, 3, 0, 0); drain();

    // Randomised traffic with random backpressure and core latency.
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
      if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(1, 20));
      sgn = 1'($urandom_range(0, 1));
      send(a, b, sgn, $urandom_range(1, 8), 0, 0);
    end
    drain();
    rand_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
